// File: rtl/text_line_editor_pkg.sv
// Shared types and default sizing for the text line editor.
// The command encoding lives here so the editor and line_modifier decode it identically.
package text_line_editor_pkg;

    localparam int              DEFAULT_COLUMNS    = 80;
    localparam int              DEFAULT_CHAR_WIDTH = 16;
    localparam logic [15:0]     DEFAULT_BLANK      = 16'h0020;

    typedef enum logic [2:0] {
        OP_PUT         = 3'd0,
        OP_ERASE_RIGHT = 3'd1,
        OP_ERASE_LEFT  = 3'd2,
        OP_ERASE_LINE  = 3'd3,
        OP_INSERT      = 3'd4,
        OP_DELETE      = 3'd5
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Codes 6 and 7 are reserved and must never produce a write.
    function automatic logic op_is_valid(input logic [2:0] op);
        return op <= 3'(OP_DELETE);
    endfunction

endpackage

// File: rtl/text_line_editor_line_modifier.sv
// Combinational per-cell rewrite of one text line for a single edit command.
// Each cell independently selects its new value; n is already clamped by the caller.
module line_modifier
    import text_line_editor_pkg::*;
#(
    parameter int                     COLUMNS    = DEFAULT_COLUMNS,
    parameter int                     CHAR_WIDTH = DEFAULT_CHAR_WIDTH,
    parameter logic [CHAR_WIDTH-1:0]  BLANK      = CHAR_WIDTH'(DEFAULT_BLANK)
) (
    input  logic [COLUMNS*CHAR_WIDTH-1:0] line,
    input  logic [2:0]                    op,
    input  logic [7:0]                    col,
    input  logic [7:0]                    n,
    input  logic [CHAR_WIDTH-1:0]         ch,
    output logic [COLUMNS*CHAR_WIDTH-1:0] new_line
);

    localparam int IW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;

    logic [CHAR_WIDTH-1:0] cells [COLUMNS];
    logic [8:0]            col_x;
    logic [8:0]            n_x;

    assign col_x = {1'b0, col};
    assign n_x   = {1'b0, n};

    genvar gi;
    generate
        for (gi = 0; gi < COLUMNS; gi++) begin : g_cell
            localparam logic [8:0] POS = 9'(gi);

            logic [8:0]            ins_src;
            logic [8:0]            del_src;
            logic [CHAR_WIDTH-1:0] cell_next;

            assign cells[gi] = line[gi*CHAR_WIDTH +: CHAR_WIDTH];
            assign ins_src   = POS - n_x;
            assign del_src   = POS + n_x;

            always_comb begin
                cell_next = cells[gi];
                case (op)
                    OP_PUT:         if (POS == col_x) cell_next = ch;
                    OP_ERASE_RIGHT: if (POS >= col_x) cell_next = BLANK;
                    OP_ERASE_LEFT:  if (POS <= col_x) cell_next = BLANK;
                    OP_ERASE_LINE:  cell_next = BLANK;
                    OP_INSERT: begin
                        if (POS >= col_x) begin
                            if (POS < col_x + n_x) cell_next = BLANK;
                            else                   cell_next = cells[ins_src[IW-1:0]];
                        end
                    end
                    OP_DELETE: begin
                        // Sources past the end of the line shift in blanks.
                        if (POS >= col_x) begin
                            if (del_src < 9'(COLUMNS)) cell_next = cells[del_src[IW-1:0]];
                            else                       cell_next = BLANK;
                        end
                    end
                    default: cell_next = cells[gi];
                endcase
            end

            assign new_line[gi*CHAR_WIDTH +: CHAR_WIDTH] = cell_next;
        end
    endgenerate

endmodule

// File: rtl/text_line_editor.sv
// Read-modify-write line editor: reads a whole text line, applies one edit, writes it back.
// Sequence per command: IDLE -> READ (RD_LATENCY cycles) -> LATCH -> WRITE -> DONE.
module text_line_editor
    import text_line_editor_pkg::*;
#(
    parameter int                     COLUMNS    = DEFAULT_COLUMNS,
    parameter int                     CHAR_WIDTH = DEFAULT_CHAR_WIDTH,
    parameter int                     ROW_WIDTH  = 8,
    parameter int                     RD_LATENCY = 2,
    parameter logic [CHAR_WIDTH-1:0]  BLANK      = CHAR_WIDTH'(DEFAULT_BLANK)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [ROW_WIDTH-1:0]          cmd_row,
    input  logic [7:0]                    cmd_col,
    input  logic [CHAR_WIDTH-1:0]         cmd_char,
    input  logic [7:0]                    cmd_count,
    output logic [ROW_WIDTH-1:0]          ram_addr,
    output logic                          ram_wren,
    output logic [COLUMNS*CHAR_WIDTH-1:0] ram_wdata,
    input  logic [COLUMNS*CHAR_WIDTH-1:0] ram_rdata,
    output logic                          done
);

    localparam logic [2:0] RD_LAST = 3'(RD_LATENCY - 1);

    state_t                        state_reg;
    logic [2:0]                    rd_cnt_reg;
    logic                          cmd_ready_reg;
    logic                          ram_wren_reg;
    logic                          done_reg;
    logic [ROW_WIDTH-1:0]          ram_addr_reg;
    logic [2:0]                    op_reg;
    logic [7:0]                    col_reg;
    logic [CHAR_WIDTH-1:0]         char_reg;
    logic [7:0]                    count_reg;
    logic [COLUMNS*CHAR_WIDTH-1:0] line_reg;

    logic                          skip_next;
    logic [7:0]                    n_next;
    logic [8:0]                    room_next;
    logic [7:0]                    n_base_next;
    logic [COLUMNS*CHAR_WIDTH-1:0] line_next;

    always_comb begin
        skip_next   = !op_is_valid(op_reg) ||
                      ((op_reg != OP_ERASE_LINE) && ({1'b0, col_reg} >= 9'(COLUMNS)));
        room_next   = 9'(COLUMNS) - {1'b0, col_reg};
        n_base_next = (count_reg == 8'd0) ? 8'd1 : count_reg;
        n_next      = n_base_next;
        if ({1'b0, n_base_next} > room_next) n_next = room_next[7:0];
    end

    line_modifier #(
        .COLUMNS    (COLUMNS),
        .CHAR_WIDTH (CHAR_WIDTH),
        .BLANK      (BLANK)
    ) u_line_modifier (
        .line     (line_reg),
        .op       (op_reg),
        .col      (col_reg),
        .n        (n_next),
        .ch       (char_reg),
        .new_line (line_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            rd_cnt_reg    <= '0;
            cmd_ready_reg <= 1'b1;
            ram_wren_reg  <= 1'b0;
            done_reg      <= 1'b0;
            ram_addr_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_reg     <= ST_READ;
                        cmd_ready_reg <= 1'b0;
                        ram_addr_reg  <= cmd_row;
                        rd_cnt_reg    <= '0;
                    end
                end
                ST_READ: begin
                    if (rd_cnt_reg == RD_LAST) state_reg  <= ST_LATCH;
                    else                       rd_cnt_reg <= rd_cnt_reg + 3'd1;
                end
                ST_LATCH: begin
                    if (skip_next) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg    <= ST_WRITE;
                        ram_wren_reg <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_reg    <= ST_DONE;
                    ram_wren_reg <= 1'b0;
                    done_reg     <= 1'b1;
                end
                ST_DONE: begin
                    state_reg     <= ST_IDLE;
                    done_reg      <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    ram_wren_reg  <= 1'b0;
                    done_reg      <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == ST_IDLE && cmd_valid) begin
            op_reg    <= cmd_op;
            col_reg   <= cmd_col;
            char_reg  <= cmd_char;
            count_reg <= cmd_count;
        end
        if (state_reg == ST_LATCH) line_reg <= ram_rdata;
    end

    // Write data is only driven while the write strobe is up, so it reads as zero out of reset.
    assign ram_wdata = ram_wren_reg ? line_next : '0;
    assign ram_addr  = ram_addr_reg;
    assign ram_wren  = ram_wren_reg;
    assign cmd_ready = cmd_ready_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_text_line_editor.sv
// Directed bench for text_line_editor with a behavioural line RAM of configurable read latency.
module tb_text_line_editor;

    localparam int COLUMNS = 80;
    localparam int CW      = 16;
    localparam int RW      = 8;
    localparam int RD_LAT  = 2;
    localparam int LW      = COLUMNS * CW;
    localparam logic [CW-1:0] BLANK = 16'h0020;

    typedef logic [LW-1:0] line_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [RW-1:0] cmd_row = '0;
    logic [7:0]    cmd_col = '0;
    logic [CW-1:0] cmd_char = '0;
    logic [7:0]    cmd_count = '0;
    logic [RW-1:0] ram_addr;
    logic          ram_wren;
    line_t         ram_wdata;
    line_t         ram_rdata;
    logic          done;

    line_t         mem [256];
    line_t         pipe [RD_LAT];
    logic          pre_en = 1'b0;
    logic [RW-1:0] pre_addr = '0;
    line_t         pre_data = '0;
    int            wr_count = 0;
    int            done_count = 0;
    logic [RW-1:0] wr_addr_log [16];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    text_line_editor #(
        .COLUMNS    (COLUMNS),
        .CHAR_WIDTH (CW),
        .ROW_WIDTH  (RW),
        .RD_LATENCY (RD_LAT),
        .BLANK      (BLANK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_char  (cmd_char),
        .cmd_count (cmd_count),
        .ram_addr  (ram_addr),
        .ram_wren  (ram_wren),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .done      (done)
    );

    always @(posedge clk) begin
        pipe[0] <= mem[ram_addr];
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
        if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
            wr_addr_log[wr_count[3:0]] <= ram_addr;
            wr_count <= wr_count + 1;
        end else if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end
        if (done) done_count <= done_count + 1;
    end
    assign ram_rdata = pipe[RD_LAT-1];

    function automatic line_t index_line();
        line_t l;
        for (int i = 0; i < COLUMNS; i++) l[i*CW +: CW] = CW'(i);
        return l;
    endfunction

    function automatic logic [CW-1:0] cell_of(input line_t l, input int i);
        return l[i*CW +: CW];
    endfunction

    function automatic int first_diff(input line_t a, input line_t b);
        for (int i = 0; i < COLUMNS; i++)
            if (a[i*CW +: CW] !== b[i*CW +: CW]) return i;
        return 0;
    endfunction

    task automatic preload(input logic [RW-1:0] row, input line_t data);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = row; pre_data = data;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Issues one command and returns the number of rising edges after the accepting
    // edge at which done was first seen high and at which cmd_ready came back (-1 if never).
    task automatic send(input logic [2:0] op, input logic [RW-1:0] row, input logic [7:0] col,
                        input logic [CW-1:0] ch, input logic [7:0] cnt,
                        output int done_edges, output int ready_edges);
        int guard;
        @(negedge clk);
        cmd_op = op; cmd_row = row; cmd_col = col; cmd_char = ch; cmd_count = cnt;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        done_edges = -1;
        ready_edges = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (done && done_edges < 0) done_edges = e;
            if (cmd_ready) begin
                ready_edges = e;
                break;
            end
        end
    endtask

    task automatic check_line(input string name, input logic [RW-1:0] row, input line_t exp);
        int k;
        vectors++;
        if (mem[row] !== exp) begin
            miscompares++;
            k = first_diff(mem[row], exp);
            $display("FAIL %s cell %0d got %h exp %h", name, k, cell_of(mem[row], k), cell_of(exp, k));
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors += 5;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
        if (ram_wren !== 1'b0)  begin miscompares++; $display("FAIL reset_wren got %b exp 0", ram_wren); end
        if (done !== 1'b0)      begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
        if (ram_addr !== '0)    begin miscompares++; $display("FAIL reset_addr got %h exp 0", ram_addr); end
        if (ram_wdata !== '0)   begin miscompares++; $display("FAIL reset_wdata got nonzero exp 0"); end
        @(negedge clk);
        rst = 1'b1;
        $display("reset: ready=%b wren=%b done=%b", cmd_ready, ram_wren, done);
    endtask

    task automatic test_put();
        line_t exp;
        int de, re, w0;
        preload(8'd3, '0);
        w0 = wr_count;
        exp = '0;
        exp[5*CW +: CW] = 16'h0041;
        // Latency is counted in edges after the accepting edge; the accept cycle itself
        // is the extra one, so done lands RD_LAT+3 cycles into the command.
        send(3'd0, 8'd3, 8'd5, 16'h0041, 8'd0, de, re);
        vectors += 4;
        if (de !== RD_LAT + 2) begin miscompares++; $display("FAIL put_done_latency got %0d exp %0d", de, RD_LAT + 2); end
        if (re !== RD_LAT + 3) begin miscompares++; $display("FAIL put_ready_latency got %0d exp %0d", re, RD_LAT + 3); end
        if (wr_count - w0 !== 1) begin miscompares++; $display("FAIL put_write_count got %0d exp 1", wr_count - w0); end
        if (wr_addr_log[w0[3:0]] !== 8'd3) begin miscompares++; $display("FAIL put_write_addr got %0d exp 3", wr_addr_log[w0[3:0]]); end
        check_line("put_line", 8'd3, exp);
        $display("put row 3 col 5: done_edges=%0d ready_edges=%0d", de, re);
    endtask

    task automatic test_edits();
        line_t idx, exp;
        int de, re;
        idx = index_line();
        // INSERT near the right edge: n clamps from 5 to 3.
        preload(8'd10, idx);
        send(3'd4, 8'd10, 8'd77, 16'h0, 8'd5, de, re);
        exp = idx;
        for (int i = 77; i < 80; i++) exp[i*CW +: CW] = BLANK;
        check_line("insert_edge", 8'd10, exp);
        $display("insert col 77 count 5: done_edges=%0d", de);
        // DELETE with count 0 behaves as count 1.
        preload(8'd11, idx);
        send(3'd5, 8'd11, 8'd0, 16'h0, 8'd0, de, re);
        for (int i = 0; i < 79; i++) exp[i*CW +: CW] = CW'(i + 1);
        exp[79*CW +: CW] = BLANK;
        check_line("delete_zero", 8'd11, exp);
        $display("delete col 0 count 0: done_edges=%0d", de);
        preload(8'd12, idx);
        send(3'd1, 8'd12, 8'd70, 16'h0, 8'd0, de, re);
        exp = idx;
        for (int i = 70; i < 80; i++) exp[i*CW +: CW] = BLANK;
        check_line("erase_right", 8'd12, exp);
        $display("erase_right col 70: done_edges=%0d", de);
        preload(8'd13, idx);
        send(3'd2, 8'd13, 8'd3, 16'h0, 8'd0, de, re);
        exp = idx;
        for (int i = 0; i <= 3; i++) exp[i*CW +: CW] = BLANK;
        check_line("erase_left", 8'd13, exp);
        $display("erase_left col 3: done_edges=%0d", de);
        preload(8'd14, idx);
        send(3'd4, 8'd14, 8'd10, 16'h0, 8'd2, de, re);
        exp = idx;
        exp[10*CW +: CW] = BLANK;
        exp[11*CW +: CW] = BLANK;
        for (int i = 12; i < 80; i++) exp[i*CW +: CW] = CW'(i - 2);
        check_line("insert_mid", 8'd14, exp);
        $display("insert col 10 count 2: done_edges=%0d", de);
        preload(8'd15, idx);
        send(3'd5, 8'd15, 8'd78, 16'h0, 8'd9, de, re);
        exp = idx;
        exp[78*CW +: CW] = BLANK;
        exp[79*CW +: CW] = BLANK;
        check_line("delete_clamp", 8'd15, exp);
        $display("delete col 78 count 9: done_edges=%0d", de);
        // ERASE_LINE ignores an out-of-range column.
        preload(8'd16, idx);
        send(3'd3, 8'd16, 8'd200, 16'h0, 8'd0, de, re);
        for (int i = 0; i < 80; i++) exp[i*CW +: CW] = BLANK;
        check_line("erase_line", 8'd16, exp);
        $display("erase_line col 200: done_edges=%0d", de);
    endtask

    task automatic test_no_write();
        int de, re, w0, d0;
        logic [2:0] ops [2];
        logic [7:0] cols [2];
        ops[0] = 3'd0; cols[0] = 8'd80;
        ops[1] = 3'd6; cols[1] = 8'd4;
        for (int t = 0; t < 2; t++) begin
            preload(8'd40, index_line());
            w0 = wr_count;
            d0 = done_count;
            send(ops[t], 8'd40, cols[t], 16'h0055, 8'd1, de, re);
            vectors += 3;
            if (wr_count !== w0) begin miscompares++; $display("FAIL nowrite_%0d writes got %0d exp 0", t, wr_count - w0); end
            if (done_count - d0 !== 1) begin miscompares++; $display("FAIL nowrite_%0d done_pulses got %0d exp 1", t, done_count - d0); end
            if (re < 0) begin miscompares++; $display("FAIL nowrite_%0d ready_timeout got %0d exp >0", t, re); end
            check_line("nowrite_line", 8'd40, index_line());
            $display("skip op %0d col %0d: writes=%0d done_edges=%0d", ops[t], cols[t], wr_count - w0, de);
        end
    endtask

    task automatic test_reset_abort();
        int w0;
        preload(8'd20, index_line());
        w0 = wr_count;
        @(negedge clk);
        cmd_op = 3'd3; cmd_row = 8'd20; cmd_col = 8'd0; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (ram_wren !== 1'b0) begin miscompares++; $display("FAIL abort_wren got %b exp 0", ram_wren); end
        @(negedge clk);
        rst = 1'b1;
        repeat (RD_LAT + 6) @(posedge clk);
        #1;
        vectors += 2;
        if (wr_count !== w0) begin miscompares++; $display("FAIL abort_writes got %0d exp 0", wr_count - w0); end
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready got %b exp 1", cmd_ready); end
        check_line("abort_line", 8'd20, index_line());
        $display("reset during read: writes=%0d ready=%b", wr_count - w0, cmd_ready);
    endtask

    task automatic test_back_to_back();
        line_t exp_a, exp_b;
        int w0, cyc, done_cyc, acc_cyc, done2;
        preload(8'd30, '0);
        preload(8'd31, '0);
        w0 = wr_count;
        @(negedge clk);
        cmd_op = 3'd0; cmd_row = 8'd30; cmd_col = 8'd0; cmd_char = 16'h00AA; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_row = 8'd31; cmd_col = 8'd1; cmd_char = 16'h00BB;
        cyc = 0; done_cyc = -1; acc_cyc = -1;
        while (acc_cyc < 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (cmd_ready) acc_cyc = cyc;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        vectors++;
        if (done_cyc < 0 || acc_cyc !== done_cyc + 1) begin
            miscompares++;
            $display("FAIL b2b_accept_cycle got %0d exp %0d", acc_cyc, done_cyc + 1);
        end
        done2 = 0;
        for (int e = 0; e < 20 && !cmd_ready; e++) begin
            @(posedge clk);
            #1;
            if (done) done2 = 1;
        end
        vectors += 4;
        if (done2 !== 1) begin miscompares++; $display("FAIL b2b_second_done got %0d exp 1", done2); end
        if (wr_count - w0 !== 2) begin miscompares++; $display("FAIL b2b_writes got %0d exp 2", wr_count - w0); end
        if (wr_addr_log[w0[3:0]] !== 8'd30) begin miscompares++; $display("FAIL b2b_first_addr got %0d exp 30", wr_addr_log[w0[3:0]]); end
        if (wr_addr_log[4'(w0 + 1)] !== 8'd31) begin miscompares++; $display("FAIL b2b_second_addr got %0d exp 31", wr_addr_log[4'(w0 + 1)]); end
        exp_a = '0; exp_a[0*CW +: CW] = 16'h00AA;
        exp_b = '0; exp_b[1*CW +: CW] = 16'h00BB;
        check_line("b2b_line_a", 8'd30, exp_a);
        check_line("b2b_line_b", 8'd31, exp_b);
        $display("back-to-back: done_cycle=%0d accept_cycle=%0d writes=%0d", done_cyc, acc_cyc, wr_count - w0);
    endtask

    initial begin
        for (int r = 0; r < 256; r++) mem[r] = '0;
        test_reset();
        test_put();
        test_edits();
        test_no_write();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
